// File: rtl/ip_if.sv
// Instruction-pointer control bus: front-end/microcode strobes into the IP
// register and the current IP back out.
interface ip_if;
    logic        start_instruction;
    logic        next_instruction;
    logic        rollback;
    logic [3:0]  inc;
    logic        wr_en;
    logic [15:0] wr_val;
    logic [15:0] val;

    modport master (
        output start_instruction,
        output next_instruction,
        output rollback,
        output inc,
        output wr_en,
        output wr_val,
        input  val
    );

    modport slave (
        input  start_instruction,
        input  next_instruction,
        input  rollback,
        input  inc,
        input  wr_en,
        input  wr_val,
        output val
    );
endinterface

// File: rtl/ip.sv
// 16-bit instruction pointer with length-based advance, absolute loads and
// rollback to the start address of the current instruction.
module ip (
    input  logic clk,
    input  logic reset,
    ip_if.slave  bus
);

    logic [15:0] cur;
    logic [15:0] start_addr;
    logic [15:0] cur_plus_inc;

    // Truncating add: wrap past 0xFFFF is intended and silent.
    assign cur_plus_inc = cur + {12'h000, bus.inc};

    // Loads beat rollback beats advance; the start capture always sees the
    // pre-edge cur, so it is unaffected by a same-cycle rollback or advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur        <= 16'h0000;
            start_addr <= 16'h0000;
        end else begin
            if (bus.wr_en) begin
                cur <= bus.wr_val;
            end else if (bus.rollback) begin
                cur <= start_addr;
            end else if (bus.start_instruction) begin
                cur <= cur_plus_inc;
            end

            if (bus.wr_en) begin
                start_addr <= bus.wr_val;
            end else if (bus.next_instruction) begin
                start_addr <= cur;
            end
        end
    end

    assign bus.val = cur;

endmodule

// File: tb/tb_ip.sv
// Directed scoreboard bench for the instruction-pointer register.
module tb_ip;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    ip_if bus ();

    ip dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_controls();
        bus.start_instruction = 1'b0;
        bus.next_instruction  = 1'b0;
        bus.rollback          = 1'b0;
        bus.inc               = 4'h0;
        bus.wr_en             = 1'b0;
        bus.wr_val            = 16'h0000;
    endtask

    task automatic check_output();
        logic [15:0] exp;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: val=%h expected=<queued value>", bus.val);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (bus.val === exp) else begin
                errors++;
                $error("[TB] FAIL %s: val=%h expected=%h", tag, bus.val, exp);
            end
        end
    endtask

    // One cycle of controls: drive at negedge, expect result after the edge.
    task automatic apply_stimulus(input logic wr, input logic [15:0] wv,
                                  input logic si, input logic [3:0] inc_amt,
                                  input logic ni, input logic rb,
                                  input logic [15:0] exp, input string tag);
        @(negedge clk);
        bus.wr_en             = wr;
        bus.wr_val            = wv;
        bus.start_instruction = si;
        bus.inc               = inc_amt;
        bus.next_instruction  = ni;
        bus.rollback          = rb;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_output();
        clear_controls();
    endtask

    task automatic load(input logic [15:0] v, input string tag);
        apply_stimulus(1'b1, v, 1'b0, 4'h0, 1'b0, 1'b0, v, tag);
    endtask

    task automatic advance(input logic [3:0] n, input logic [15:0] exp, input string tag);
        apply_stimulus(1'b0, 16'h0000, 1'b1, n, 1'b0, 1'b0, exp, tag);
    endtask

    task automatic roll(input logic [15:0] exp, input string tag);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, exp, tag);
    endtask

    task automatic mark_start(input logic [15:0] exp, input string tag);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, exp, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_controls();
        reset = 1'b0;

        #3;
        exp_q.push_back(16'h0000); tag_q.push_back("reset_held");
        check_output();

        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, "after_release");

        load(16'h1234, "load_1234");

        load(16'h0100, "load_0100");
        advance(4'd1, 16'h0101, "inc_1");
        advance(4'd2, 16'h0103, "inc_2");
        advance(4'd5, 16'h0108, "inc_5");

        load(16'h3000, "load_3000");
        advance(4'd0, 16'h3000, "inc_0");
        load(16'h4000, "load_4000");
        advance(4'd15, 16'h400F, "inc_15");

        load(16'hFFFE, "load_fffe");
        advance(4'd5, 16'h0003, "wrap");

        apply_stimulus(1'b1, 16'h0500, 1'b1, 4'd10, 1'b0, 1'b0, 16'h0500, "wr_beats_inc");

        apply_stimulus(1'b1, 16'h2000, 1'b0, 4'h0, 1'b1, 1'b0, 16'h2000, "load_with_ni");
        advance(4'd2, 16'h2002, "rb_inc_2");
        advance(4'd3, 16'h2005, "rb_inc_3");
        roll(16'h2000, "rollback_2000");

        load(16'h0300, "load_0300");
        apply_stimulus(1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b0, 16'h0300, "ni_ignores_inc");
        advance(4'd4, 16'h0304, "inc_4_after_ni");
        roll(16'h0300, "rollback_0300");

        load(16'h0100, "load_0100_b");
        mark_start(16'h0100, "ni_0100");
        advance(4'd4, 16'h0104, "inc_4_first");
        mark_start(16'h0104, "ni_0104");
        advance(4'd2, 16'h0106, "inc_2_second");
        roll(16'h0104, "rollback_0104");

        load(16'h0A00, "load_0a00");
        advance(4'd6, 16'h0A06, "inc_6");
        apply_stimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 16'h0A00, "ni_with_rb");
        roll(16'h0A06, "rollback_pre_edge");
        apply_stimulus(1'b0, 16'h0000, 1'b1, 4'd3, 1'b0, 1'b1, 16'h0A06, "rb_beats_inc");

        apply_stimulus(1'b1, 16'h0B00, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0B00, "wr_beats_ni");
        advance(4'd1, 16'h0B01, "inc_after_wr_ni");
        roll(16'h0B00, "rollback_0b00");

        apply_stimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0B00, "idle_hold");

        load(16'h1000, "load_1000");
        advance(4'd5, 16'h1005, "inc_to_1005");
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(16'h0000); tag_q.push_back("async_reset");
        check_output();
        @(negedge clk);
        reset = 1'b1;
        advance(4'd3, 16'h0003, "inc_after_reset");
        roll(16'h0000, "rollback_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
